// File: rtl/mem_port_if.sv
// mem_port_if: request/response handshake plus RAM control bundle for mem_port.
//   slave  modport: mem_port side (accepts requests, issues responses, drives RAM controls).
//   master modport: core/RAM side (issues requests, consumes responses, returns RAM read data).
//   Request : I_req_valid/O_req_ready, I_req_write, I_req_size, I_req_signed, I_req_addr, I_req_data
//   Response: O_rsp_valid/I_rsp_ready, O_rsp_data, O_rsp_fault
//   RAM     : O_ram_enable, O_ram_write, O_ram_size, O_ram_addr, O_ram_data, I_ram_data
interface mem_port_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          I_req_valid;
  logic          O_req_ready;
  logic          I_req_write;
  logic [1:0]    I_req_size;
  logic          I_req_signed;
  logic [AW-1:0] I_req_addr;
  logic [DW-1:0] I_req_data;

  logic          O_rsp_valid;
  logic          I_rsp_ready;
  logic [DW-1:0] O_rsp_data;
  logic          O_rsp_fault;

  logic          O_ram_enable;
  logic          O_ram_write;
  logic [1:0]    O_ram_size;
  logic [AW-1:0] O_ram_addr;
  logic [DW-1:0] O_ram_data;
  logic [DW-1:0] I_ram_data;

  modport slave (
    input  I_req_valid, I_req_write, I_req_size, I_req_signed, I_req_addr, I_req_data,
    input  I_rsp_ready, I_ram_data,
    output O_req_ready, O_rsp_valid, O_rsp_data, O_rsp_fault,
    output O_ram_enable, O_ram_write, O_ram_size, O_ram_addr, O_ram_data
  );

  modport master (
    output I_req_valid, I_req_write, I_req_size, I_req_signed, I_req_addr, I_req_data,
    output I_rsp_ready, I_ram_data,
    input  O_req_ready, O_rsp_valid, O_rsp_data, O_rsp_fault,
    input  O_ram_enable, O_ram_write, O_ram_size, O_ram_addr, O_ram_data
  );
endinterface

// File: rtl/mem_port.sv
// mem_port: single-outstanding load/store initiator for the byte-addressed ram block.
//   I_clk   : clock
//   I_reset : synchronous active-high reset (shared with the ram)
//   bus     : mem_port_if.slave -- request handshake, response handshake, RAM controls
//   MEM_TOP : highest legal byte address; a word access needs addr+1 <= MEM_TOP
// All outputs are registered. Sequence: IDLE -> ACCESS -> (CAPTURE) -> RESP -> IDLE,
// with faulting requests going straight from IDLE to RESP without touching the RAM.
module mem_port #(
  parameter logic [15:0] MEM_TOP = 16'h07FF
) (
  input  logic       I_clk,
  input  logic       I_reset,
  mem_port_if.slave  bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t        r_state,      w_state;
  logic          r_write,      w_write;
  logic [1:0]    r_size,       w_size;
  logic          r_signed,     w_signed;
  logic          r_req_ready,  w_req_ready;
  logic          r_rsp_valid,  w_rsp_valid;
  logic [DW-1:0] r_rsp_data,   w_rsp_data;
  logic          r_rsp_fault,  w_rsp_fault;
  logic          r_ram_enable, w_ram_enable;
  logic          r_ram_write,  w_ram_write;
  logic [1:0]    r_ram_size,   w_ram_size;
  logic [AW-1:0] r_ram_addr,   w_ram_addr;
  logic [DW-1:0] r_ram_data,   w_ram_data;

  logic          w_fault;
  logic [DW-1:0] w_load_data;

  // Illegal size, out-of-range byte, or word whose upper byte falls past MEM_TOP.
  always_comb begin
    w_fault = 1'b0;
    if ((bus.I_req_size != 2'd1) && (bus.I_req_size != 2'd2)) w_fault = 1'b1;
    if (bus.I_req_addr > MEM_TOP)                              w_fault = 1'b1;
    if ((bus.I_req_size == 2'd2) && (bus.I_req_addr >= MEM_TOP)) w_fault = 1'b1;
  end

  // Load result formatting from the RAM read data visible in CAPTURE.
  always_comb begin
    w_load_data = {8'h00, bus.I_ram_data[7:0]};
    if (r_size == 2'd2)
      w_load_data = bus.I_ram_data;
    else if (r_signed)
      w_load_data = {{8{bus.I_ram_data[7]}}, bus.I_ram_data[7:0]};
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state      = r_state;
    w_write      = r_write;
    w_size       = r_size;
    w_signed     = r_signed;
    w_rsp_data   = r_rsp_data;
    w_rsp_fault  = r_rsp_fault;
    w_ram_enable = 1'b0;
    w_ram_write  = r_ram_write;
    w_ram_size   = r_ram_size;
    w_ram_addr   = r_ram_addr;
    w_ram_data   = r_ram_data;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.I_req_valid && r_req_ready) begin
          w_write  = bus.I_req_write;
          w_size   = bus.I_req_size;
          w_signed = bus.I_req_signed;
          if (w_fault) begin
            w_state     = ST_RESP;
            w_rsp_fault = 1'b1;
            w_rsp_data  = '0;
          end else begin
            // RAM controls are loaded only for legal requests so they hold otherwise.
            w_state      = ST_ACCESS;
            w_ram_enable = 1'b1;
            w_ram_write  = bus.I_req_write;
            w_ram_size   = bus.I_req_size;
            w_ram_addr   = bus.I_req_addr;
            w_ram_data   = bus.I_req_data;
          end
        end
      end
      ST_ACCESS: begin
        if (r_write) begin
          w_state     = ST_RESP;
          w_rsp_data  = '0;
          w_rsp_fault = 1'b0;
        end else begin
          w_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_state     = ST_RESP;
        w_rsp_data  = w_load_data;
        w_rsp_fault = 1'b0;
      end
      ST_RESP: begin
        if (bus.I_rsp_ready) begin
          w_state     = ST_IDLE;
          w_rsp_data  = '0;
          w_rsp_fault = 1'b0;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    w_req_ready = (w_state == ST_IDLE);
    w_rsp_valid = (w_state == ST_RESP);
  end

  // State and output registers.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_fault  <= 1'b0;
      r_ram_enable <= 1'b0;
      r_ram_write  <= 1'b0;
      r_ram_size   <= 2'd0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
    end else begin
      r_state      <= w_state;
      r_write      <= w_write;
      r_size       <= w_size;
      r_signed     <= w_signed;
      r_req_ready  <= w_req_ready;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_data   <= w_rsp_data;
      r_rsp_fault  <= w_rsp_fault;
      r_ram_enable <= w_ram_enable;
      r_ram_write  <= w_ram_write;
      r_ram_size   <= w_ram_size;
      r_ram_addr   <= w_ram_addr;
      r_ram_data   <= w_ram_data;
    end
  end

  assign bus.O_req_ready  = r_req_ready;
  assign bus.O_rsp_valid  = r_rsp_valid;
  assign bus.O_rsp_data   = r_rsp_data;
  assign bus.O_rsp_fault  = r_rsp_fault;
  assign bus.O_ram_enable = r_ram_enable;
  assign bus.O_ram_write  = r_ram_write;
  assign bus.O_ram_size   = r_ram_size;
  assign bus.O_ram_addr   = r_ram_addr;
  assign bus.O_ram_data   = r_ram_data;
endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: directed bench for mem_port with a behavioural byte-addressed ram
// (registered read data, shared reset, power-up mem[1]=0x80, all else 0).
module tb_mem_port;
  logic I_clk;
  logic I_reset;
  int   checks;
  int   errors;
  int   en_cnt;

  mem_port_if bus ();

  mem_port #(.MEM_TOP(16'h07FF)) dut (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .bus     (bus.slave)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Behavioural ram: one-cycle registered read, ignores enable while in reset.
  logic [7:0]  mem [0:2047];
  logic [15:0] ram_dout;
  assign bus.I_ram_data = ram_dout;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[1]   = 8'h80;
    ram_dout = 16'h0000;
  end

  always @(posedge I_clk) begin
    if (bus.O_ram_enable) en_cnt <= en_cnt + 1;
    if (!I_reset && bus.O_ram_enable) begin
      if (bus.O_ram_write) begin
        mem[bus.O_ram_addr[10:0]] <= bus.O_ram_data[7:0];
        if (bus.O_ram_size == 2'd2)
          mem[11'(bus.O_ram_addr[10:0] + 11'd1)] <= bus.O_ram_data[15:8];
      end else if (bus.O_ram_size == 2'd2) begin
        ram_dout <= {mem[11'(bus.O_ram_addr[10:0] + 11'd1)], mem[bus.O_ram_addr[10:0]]};
      end else begin
        ram_dout <= {8'h00, mem[bus.O_ram_addr[10:0]]};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},  32'(bus.O_req_ready),  32'd1);
    check({tag, ".rsp_valid"},  32'(bus.O_rsp_valid),  32'd0);
    check({tag, ".rsp_data"},   32'(bus.O_rsp_data),   32'd0);
    check({tag, ".rsp_fault"},  32'(bus.O_rsp_fault),  32'd0);
    check({tag, ".ram_enable"}, 32'(bus.O_ram_enable), 32'd0);
    check({tag, ".ram_write"},  32'(bus.O_ram_write),  32'd0);
    check({tag, ".ram_size"},   32'(bus.O_ram_size),   32'd0);
    check({tag, ".ram_addr"},   32'(bus.O_ram_addr),   32'd0);
    check({tag, ".ram_data"},   32'(bus.O_ram_data),   32'd0);
  endtask

  // One full transaction with rsp_ready high; lat = cycle index (from accept) where rsp_valid is first seen.
  task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic flt, output int lat);
    int n;
    n = 0;
    while (!bus.O_req_ready && n < 20) begin tick(); n++; end
    bus.I_req_valid  = 1'b1;
    bus.I_req_write  = wr;
    bus.I_req_size   = sz;
    bus.I_req_signed = sg;
    bus.I_req_addr   = a;
    bus.I_req_data   = d;
    bus.I_rsp_ready  = 1'b1;
    tick();
    bus.I_req_valid = 1'b0;
    lat = 1;
    while (!bus.O_rsp_valid && lat < 10) begin tick(); lat++; end
    rd  = bus.O_rsp_data;
    flt = bus.O_rsp_fault;
    tick();
    bus.I_rsp_ready = 1'b0;
  endtask

  logic [15:0] rd;
  logic        flt;
  int          lat;
  int          en_before;
  int          n;

  initial begin
    checks = 0;
    errors = 0;
    en_cnt = 0;
    bus.I_req_valid  = 1'b0;
    bus.I_req_write  = 1'b0;
    bus.I_req_size   = 2'd0;
    bus.I_req_signed = 1'b0;
    bus.I_req_addr   = 16'h0000;
    bus.I_req_data   = 16'h0000;
    bus.I_rsp_ready  = 1'b0;
    I_reset = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    I_reset = 1'b0;
    tick();

    // Power-up contents.
    xact(1'b0, 2'd2, 1'b0, 16'h0000, 16'h0000, rd, flt, lat);
    check("pwrup.data", 32'(rd), 32'h8000);
    check("pwrup.lat",  32'(lat), 32'd3);

    // Word round trip.
    xact(1'b1, 2'd2, 1'b0, 16'h0100, 16'h1234, rd, flt, lat);
    check("st_w.lat",   32'(lat), 32'd2);
    check("st_w.data",  32'(rd),  32'h0000);
    check("st_w.fault", 32'(flt), 32'd0);
    xact(1'b0, 2'd2, 1'b0, 16'h0100, 16'h0000, rd, flt, lat);
    check("ld_w.data",  32'(rd),  32'h1234);
    check("ld_w.fault", 32'(flt), 32'd0);
    check("ld_w.lat",   32'(lat), 32'd3);

    // Byte extension.
    xact(1'b0, 2'd1, 1'b0, 16'h0100, 16'h0000, rd, flt, lat);
    check("ld_bu100", 32'(rd), 32'h0034);
    xact(1'b1, 2'd1, 1'b0, 16'h0101, 16'h5580, rd, flt, lat);
    check("st_b.lat", 32'(lat), 32'd2);
    xact(1'b0, 2'd1, 1'b1, 16'h0101, 16'h0000, rd, flt, lat);
    check("ld_bs101", 32'(rd), 32'hFF80);
    xact(1'b0, 2'd1, 1'b0, 16'h0101, 16'h0000, rd, flt, lat);
    check("ld_bu101", 32'(rd), 32'h0080);

    // Faults: no RAM cycle, response one cycle after accept.
    en_before = en_cnt;
    xact(1'b0, 2'd2, 1'b0, 16'h07FF, 16'h0000, rd, flt, lat);
    check("f_w7ff.fault", 32'(flt), 32'd1);
    check("f_w7ff.data",  32'(rd),  32'd0);
    check("f_w7ff.lat",   32'(lat), 32'd1);
    xact(1'b1, 2'd1, 1'b0, 16'h0800, 16'h00AA, rd, flt, lat);
    check("f_b800.fault", 32'(flt), 32'd1);
    check("f_b800.data",  32'(rd),  32'd0);
    check("f_b800.lat",   32'(lat), 32'd1);
    xact(1'b0, 2'd3, 1'b0, 16'h0010, 16'h0000, rd, flt, lat);
    check("f_sz3.fault",  32'(flt), 32'd1);
    check("f_sz3.data",   32'(rd),  32'd0);
    check("f_sz3.lat",    32'(lat), 32'd1);
    check("f.no_enable",  32'(en_cnt - en_before), 32'd0);

    // Backpressure: word load held in RESP with a second request pending.
    bus.I_rsp_ready  = 1'b0;
    bus.I_req_valid  = 1'b1;
    bus.I_req_write  = 1'b0;
    bus.I_req_size   = 2'd2;
    bus.I_req_signed = 1'b0;
    bus.I_req_addr   = 16'h0100;
    tick();
    bus.I_req_size = 2'd1;
    bus.I_req_addr = 16'h0101;
    n = 0;
    while (!bus.O_rsp_valid && n < 10) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp.rsp_valid", 32'(bus.O_rsp_valid), 32'd1);
      check("bp.rsp_data",  32'(bus.O_rsp_data),  32'h8034);
      check("bp.rsp_fault", 32'(bus.O_rsp_fault), 32'd0);
      check("bp.req_ready", 32'(bus.O_req_ready), 32'd0);
      tick();
    end
    bus.I_rsp_ready = 1'b1;
    tick();
    check("bp.hs.req_ready", 32'(bus.O_req_ready), 32'd1);
    check("bp.hs.rsp_valid", 32'(bus.O_rsp_valid), 32'd0);
    check("bp.hs.rsp_data",  32'(bus.O_rsp_data),  32'd0);
    tick();
    check("bp.acc.req_ready",  32'(bus.O_req_ready),  32'd0);
    check("bp.acc.ram_enable", 32'(bus.O_ram_enable), 32'd1);
    bus.I_req_valid = 1'b0;
    n = 0;
    while (!bus.O_rsp_valid && n < 10) begin tick(); n++; end
    check("bp.pend.data", 32'(bus.O_rsp_data), 32'h0080);
    check("bp.pend.lat",  32'(n), 32'd2);
    tick();
    bus.I_rsp_ready = 1'b0;

    // Reset during the ACCESS cycle of a store.
    bus.I_req_valid = 1'b1;
    bus.I_req_write = 1'b1;
    bus.I_req_size  = 2'd2;
    bus.I_req_addr  = 16'h0200;
    bus.I_req_data  = 16'hBEEF;
    tick();
    bus.I_req_valid = 1'b0;
    check("rst.access.enable", 32'(bus.O_ram_enable), 32'd1);
    check("rst.access.write",  32'(bus.O_ram_write),  32'd1);
    I_reset = 1'b1;
    tick();
    check_reset_outputs("rst_midop");
    I_reset = 1'b0;
    tick();
    check("rst.no_rsp", 32'(bus.O_rsp_valid), 32'd0);
    xact(1'b0, 2'd2, 1'b0, 16'h0200, 16'h0000, rd, flt, lat);
    check("rst.ld200", 32'(rd), 32'h0000);
    check("rst.ld200.fault", 32'(flt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port.md
# mem_port

Core-side initiator for the byte-addressed `ram` block. It accepts one load or store request at a time from the CPU datapath and sequences the RAM's enable/size/write protocol, including its one-cycle registered read latency. It range-checks addresses, sign- or zero-extends byte loads, and returns a response under a valid/ready handshake. It sits between the core's load/store and fetch logic and the single `ram` instance, and owns every RAM control input.

## Interface
Parameters:
- `MEM_TOP`, default 12'h7FF: highest legal byte address. A word access needs `addr+1 <= MEM_TOP`.

Ports:
- `I_clk` in 1: clock; the only clock.
- `I_reset` in 1: synchronous, active-high reset. The same net drives `ram.I_reset`.
- `I_req_valid` in 1: request present.
- `O_req_ready` out 1: high only in IDLE.
- `I_req_write` in 1: 1 = store, 0 = load.
- `I_req_size` in 2: 1 = byte, 2 = word; 0 and 3 are illegal.
- `I_req_signed` in 1: sign-extend byte loads.
- `I_req_addr` in 16: byte address.
- `I_req_data` in 16: store data; bytes use [7:0].
- `O_rsp_valid` out 1: response present.
- `I_rsp_ready` in 1: response consumed.
- `O_rsp_data` out 16: load data; 0 for stores and faults.
- `O_rsp_fault` out 1: the request was rejected and never reached RAM.
- `O_ram_enable` out 1: drives `ram.I_enable`.
- `O_ram_write` out 1: drives `ram.I_write`.
- `O_ram_size` out 2: drives `ram.I_size`.
- `O_ram_addr` out 16: drives `ram.I_addr`.
- `O_ram_data` out 16: drives `ram.I_data_in`.
- `I_ram_data` in 16: from `ram.O_data_out`.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP. All outputs are registered.
- IDLE:
  - On `I_req_valid && O_req_ready`, latch write, size, signed, addr and data.
  - Fault check: size is not 1 or 2; or `addr > MEM_TOP`; or size 2 with `addr >= MEM_TOP`.
  - Fault: go to RESP with `O_rsp_fault=1` and `O_rsp_data=0`. No RAM cycle is issued.
  - No fault: go to ACCESS.
- ACCESS:
  - Drive `O_ram_enable=1` for exactly one cycle, with the latched write, size, addr and data.
  - Store: go to RESP with `O_rsp_data=0`.
  - Load: go to CAPTURE.
- CAPTURE: `I_ram_data` is valid this cycle. Register the result and go to RESP.
  - Word load: result = `I_ram_data`, little-endian (low byte at addr).
  - Unsigned byte load: result = `{8'h00, I_ram_data[7:0]}`.
  - Signed byte load: result = `{{8{I_ram_data[7]}}, I_ram_data[7:0]}`.
- RESP:
  - `O_rsp_valid=1`; data and fault stay stable until `I_rsp_ready`.
  - On `I_rsp_ready`, go to IDLE and clear `O_rsp_valid`, `O_rsp_data` and `O_rsp_fault` on the same edge.
- `O_ram_enable` is 0 in every state except ACCESS. `O_ram_*` hold their last values when enable is 0.
- No request queueing: `O_req_ready=0` outside IDLE. A request held while busy is accepted on the first IDLE cycle.

## Timing
- Reset (synchronous, edge with `I_reset=1`):
  - State goes to IDLE.
  - `O_req_ready=1`. Every other output is 0: `O_rsp_valid`, `O_rsp_data`, `O_rsp_fault`, `O_ram_enable`, `O_ram_write`, `O_ram_size`, `O_ram_addr`, `O_ram_data`.
- Reset mid-operation:
  - Any in-flight request is dropped and no response is issued.
  - If reset is high during the ACCESS cycle, the RAM ignores the enable (shared reset), so no write occurs.
- Latency, from the accept edge E0 to `O_rsp_valid` first high:
  - Load: 3 cycles (ACCESS, CAPTURE, RESP).
  - Store: 2 cycles.
  - Fault: 1 cycle.
- Back-to-back throughput: one load every 4 cycles and one store every 3 cycles when `I_rsp_ready` is held high. IDLE always takes one cycle.
- Simultaneous events: a request presented in the same cycle that RESP completes is not accepted until the following IDLE cycle.

## Test plan
- Word round trip: store word 0x1234 at 0x0100, then load word at 0x0100.
  - Load response data 0x1234, fault 0.
  - The store response arrives 2 cycles after accept and the load response 3 cycles after accept.
- Byte extension: load bytes from 0x0100 after the word store above.
  - Unsigned byte at 0x0100 returns 0x0034.
  - Then store byte 0x80 at 0x0101. Signed byte load at 0x0101 returns 0xFF80; unsigned returns 0x0080.
- Power-up contents: after reset, load word at 0x0000.
  - Returns 0x8000 (mem[0]=0x00, mem[1]=0x80).
- Faults: each of the following returns `O_rsp_fault=1` and data 0 one cycle after accept, with `O_ram_enable` never asserted.
  - Word load at 0x07FF.
  - Byte store at 0x0800.
  - Load with size 3.
- Backpressure: hold `I_rsp_ready=0` for 5 cycles in RESP.
  - `O_rsp_valid`, `O_rsp_data` and `O_rsp_fault` stay stable.
  - `O_req_ready` stays 0.
  - A pending request is accepted in the cycle after the handshake.
- Reset mid-op: assert reset during the ACCESS cycle of a store of 0xBEEF to 0x0200, then load word at 0x0200.
  - The load returns the prior contents (0x0000).
  - All outputs were at their reset values on the edge after reset.
